// File: rtl/reset_request_ctrl.sv
// Reset request initiator: turns software and fault requests into a fixed-width
// active-low reset pulse, waits for the synchronizer's acknowledge, then holds off.
module reset_request_ctrl #(
    parameter int unsigned PULSE_CYCLES   = 16,
    parameter int unsigned ACK_TIMEOUT    = 1024,
    parameter int unsigned HOLDOFF_CYCLES = 256,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw_req,
    input  logic             fault_in,
    input  logic             reset_ack,
    input  logic             enable,
    output logic             rst_req_n,
    output logic             busy,
    output logic [1:0]       cause,
    output logic             timeout,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int unsigned MAX_A = (PULSE_CYCLES > ACK_TIMEOUT) ? PULSE_CYCLES : ACK_TIMEOUT;
    localparam int unsigned MAX_N = (MAX_A > HOLDOFF_CYCLES) ? MAX_A : HOLDOFF_CYCLES;
    localparam int unsigned TMR_W = (MAX_N > 2) ? $clog2(MAX_N) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_ACK = 2'd2,
        HOLDOFF  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nx;
    logic             accept;
    logic             expire;

    logic fault_s1;
    logic fault_s2;
    logic fault_s3;
    logic fault_qual;
    logic fault_qual_d;
    logic fault_edge;
    logic ack_s1;
    logic ack_s2;
    logic ack_low_seen;
    logic ack_seen;

    logic             rst_req_n_nx;
    logic             busy_nx;
    logic [1:0]       cause_nx;
    logic             timeout_nx;
    logic [CNT_W-1:0] event_cnt_nx;

    // Fault must be high on two consecutive synchronized samples; only its rising edge requests.
    assign fault_qual = fault_s2 & fault_s3;
    assign fault_edge = fault_qual & ~fault_qual_d;
    // Ack needs a low sighting inside WAIT_ACK first, so a stale high level never completes.
    assign ack_seen   = ack_low_seen & ack_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_s1     <= 1'b0;
            fault_s2     <= 1'b0;
            fault_s3     <= 1'b0;
            fault_qual_d <= 1'b0;
            ack_s1       <= 1'b0;
            ack_s2       <= 1'b0;
            ack_low_seen <= 1'b0;
        end else begin
            fault_s1     <= fault_in;
            fault_s2     <= fault_s1;
            fault_s3     <= fault_s2;
            fault_qual_d <= fault_qual;
            ack_s1       <= reset_ack;
            ack_s2       <= ack_s1;
            ack_low_seen <= (state == WAIT_ACK) & (ack_low_seen | ~ack_s2);
        end
    end

    // State register together with the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tmr       <= '0;
            rst_req_n <= 1'b1;
            busy      <= 1'b0;
            cause     <= 2'b00;
            timeout   <= 1'b0;
            event_cnt <= '0;
        end else begin
            state     <= state_nx;
            tmr       <= tmr_nx;
            rst_req_n <= rst_req_n_nx;
            busy      <= busy_nx;
            cause     <= cause_nx;
            timeout   <= timeout_nx;
            event_cnt <= event_cnt_nx;
        end
    end

    // Next-state logic; the shared timer restarts from zero on every transition.
    always_comb begin
        state_nx = state;
        tmr_nx   = tmr + TMR_W'(1);
        accept   = 1'b0;
        expire   = 1'b0;
        case (state)
            IDLE: begin
                tmr_nx = '0;
                if (enable && (sw_req || fault_edge)) begin
                    accept   = 1'b1;
                    state_nx = ASSERT;
                end
            end
            ASSERT: begin
                if (tmr == TMR_W'(PULSE_CYCLES - 1)) begin
                    state_nx = WAIT_ACK;
                    tmr_nx   = '0;
                end
            end
            WAIT_ACK: begin
                if (ack_seen) begin
                    state_nx = HOLDOFF;
                    tmr_nx   = '0;
                end else if (tmr == TMR_W'(ACK_TIMEOUT - 1)) begin
                    expire   = 1'b1;
                    state_nx = HOLDOFF;
                    tmr_nx   = '0;
                end
            end
            HOLDOFF: begin
                if (tmr == TMR_W'(HOLDOFF_CYCLES - 1)) begin
                    state_nx = IDLE;
                    tmr_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                tmr_nx   = '0;
            end
        endcase
    end

    // Output values for the next cycle, decoded from the next state.
    always_comb begin
        rst_req_n_nx = (state_nx != ASSERT);
        busy_nx      = (state_nx != IDLE);
        cause_nx     = cause;
        timeout_nx   = timeout | expire;
        event_cnt_nx = event_cnt;
        if (accept) begin
            cause_nx = {fault_edge, sw_req};
            if (event_cnt != {CNT_W{1'b1}}) begin
                event_cnt_nx = event_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_reset_request_ctrl.sv
// Self-checking bench: directed sequences on a default-parameter instance, plus a
// vector table, randomized model comparison and counter saturation on a short-timing instance.
module tb_reset_request_ctrl;

    localparam int unsigned SP = 3;
    localparam int unsigned ST = 12;
    localparam int unsigned SH = 6;
    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, sw_req, fault_in, reset_ack, enable;
    logic       rst_req_n, busy, timeout;
    logic [1:0] cause;
    logic [7:0] event_cnt;

    logic       s_rst, s_sw, s_fault, s_ack, s_en;
    logic       s_rstn, s_busy, s_timeout;
    logic [1:0] s_cause;
    logic [7:0] s_cnt;

    reset_request_ctrl u_dut (
        .clk(clk), .rst(rst), .sw_req(sw_req), .fault_in(fault_in), .reset_ack(reset_ack),
        .enable(enable), .rst_req_n(rst_req_n), .busy(busy), .cause(cause),
        .timeout(timeout), .event_cnt(event_cnt)
    );

    reset_request_ctrl #(
        .PULSE_CYCLES(SP), .ACK_TIMEOUT(ST), .HOLDOFF_CYCLES(SH), .CNT_W(CW)
    ) u_small (
        .clk(clk), .rst(s_rst), .sw_req(s_sw), .fault_in(s_fault), .reset_ack(s_ack),
        .enable(s_en), .rst_req_n(s_rstn), .busy(s_busy), .cause(s_cause),
        .timeout(s_timeout), .event_cnt(s_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles rst_req_n stays low, starting from a sample that is already low.
    task automatic pulse_len(output int n);
        n = 0;
        while (!rst_req_n && n < 40) begin
            n++;
            tick();
        end
    endtask

    // Acknowledge low-then-high once in WAIT_ACK; return cycles from ack rise to idle.
    task automatic ack_cycle(input int poke, output int n, output logic saw_low);
        int k = 0;
        while (!rst_req_n && k < 100) begin
            tick();
            k++;
        end
        reset_ack = 1'b0;
        repeat (4) tick();
        reset_ack = 1'b1;
        n = 0;
        saw_low = 1'b0;
        while (busy && n < 400) begin
            sw_req = (n == poke);
            tick();
            n++;
            if (!rst_req_n) saw_low = 1'b1;
        end
        sw_req = 1'b0;
    endtask

    // Reference model: phases with countdowns; inputs seen through a sample delay line.
    int         m_phase, m_left, m_wait, m_cnt;
    logic       m_low, m_to;
    logic [1:0] m_cause;
    logic [3:0] m_fh;
    logic [1:0] m_ah;

    task automatic m_reset();
        m_phase = 0; m_left = 0; m_wait = 0; m_cnt = 0;
        m_low = 1'b0; m_to = 1'b0; m_cause = 2'b00; m_fh = '0; m_ah = '0;
    endtask

    task automatic m_step(input logic en, input logic sw, input logic flt, input logic ack);
        logic fedge, sa;
        // Sample k-2 and k-3 high with k-4 low: first qualified edge after two syncs.
        fedge = m_fh[1] & m_fh[2] & ~m_fh[3];
        sa    = m_ah[1];
        case (m_phase)
            0: if (en && (sw || fedge)) begin
                m_cause = {fedge, sw};
                if (m_cnt < 255) m_cnt++;
                m_phase = 1;
                m_left  = SP;
            end
            1: begin
                m_left--;
                if (m_left == 0) begin m_phase = 2; m_wait = 0; m_low = 1'b0; end
            end
            2: begin
                if (m_low && sa) begin
                    m_phase = 3; m_left = SH;
                end else if (m_wait == ST - 1) begin
                    m_to = 1'b1; m_phase = 3; m_left = SH;
                end else begin
                    m_wait++;
                end
                m_low = m_low | ~sa;
            end
            default: begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
        endcase
        m_fh = {m_fh[2:0], flt};
        m_ah = {m_ah[0], ack};
    endtask

    function automatic int m_outs();
        logic [12:0] v;
        v = {m_phase != 1, m_phase != 0, m_cause, m_to, 8'(m_cnt)};
        return int'(v);
    endfunction

    typedef struct {
        logic       en;
        logic       sw;
        int         flen;
        logic       exp_busy;
        logic [1:0] exp_cause;
        int         exp_cnt;
    } vec_t;

    vec_t vt[8];

    initial begin
        int   n;
        logic saw;
        logic [12:0] dv;

        vt[0] = '{1'b1, 1'b1, 0, 1'b1, 2'b01, 1};
        vt[1] = '{1'b0, 1'b1, 0, 1'b0, 2'b01, 1};
        vt[2] = '{1'b1, 1'b0, 1, 1'b0, 2'b01, 1};
        vt[3] = '{1'b1, 1'b0, 4, 1'b1, 2'b10, 2};
        vt[4] = '{1'b1, 1'b1, 4, 1'b1, 2'b11, 3};
        vt[5] = '{1'b0, 1'b0, 4, 1'b0, 2'b11, 3};
        vt[6] = '{1'b1, 1'b1, 1, 1'b1, 2'b01, 4};
        vt[7] = '{1'b1, 1'b0, 0, 1'b0, 2'b01, 4};

        rst = 1'b1; sw_req = 1'b0; fault_in = 1'b0; reset_ack = 1'b1; enable = 1'b1;
        s_rst = 1'b1; s_sw = 1'b0; s_fault = 1'b0; s_ack = 1'b1; s_en = 1'b1;
        repeat (3) tick();
        chk("reset_rst_req_n", rst_req_n, 1);
        chk("reset_busy", busy, 0);
        chk("reset_cause", cause, 0);
        chk("reset_timeout", timeout, 0);
        chk("reset_event_cnt", event_cnt, 0);
        rst = 1'b0;
        s_rst = 1'b0;

        // Software request, full handshake, and a poke during holdoff.
        repeat (10) tick();
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        chk("sw_cause", cause, 1);
        chk("sw_event_cnt", event_cnt, 1);
        chk("sw_busy", busy, 1);
        pulse_len(n);
        chk("sw_pulse_len", n, 16);
        ack_cycle(100, n, saw);
        chk("sw_ack_to_idle", n, 259);
        chk("holdoff_poke_no_pulse", saw, 0);
        chk("holdoff_poke_cnt", event_cnt, 1);

        // Request with enable low is dropped.
        enable = 1'b0;
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        tick();
        chk("disabled_rst_req_n", rst_req_n, 1);
        chk("disabled_busy", busy, 0);
        chk("disabled_cnt", event_cnt, 1);
        enable = 1'b1;

        // One-cycle fault glitch is rejected.
        fault_in = 1'b1;
        tick();
        fault_in = 1'b0;
        repeat (8) tick();
        chk("glitch_busy", busy, 0);
        chk("glitch_cnt", event_cnt, 1);

        // Held fault: one request, no retrigger after holdoff.
        fault_in = 1'b1;
        n = 0;
        while (rst_req_n && n < 10) begin tick(); n++; end
        chk("fault_latency", n, 4);
        chk("fault_cause", cause, 2);
        chk("fault_cnt", event_cnt, 2);
        ack_cycle(-1, n, saw);
        chk("fault_ack_to_idle", n, 259);
        repeat (20) tick();
        chk("fault_held_busy", busy, 0);
        chk("fault_held_cnt", event_cnt, 2);
        fault_in = 1'b0;
        repeat (10) tick();

        // Software strobe coinciding with the qualified fault edge.
        fault_in = 1'b1;
        repeat (3) tick();
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        chk("both_rst_req_n", rst_req_n, 0);
        chk("both_cause", cause, 3);
        chk("both_cnt", event_cnt, 3);
        pulse_len(n);
        chk("both_pulse_len", n, 16);
        ack_cycle(-1, n, saw);
        chk("both_ack_to_idle", n, 259);
        fault_in = 1'b0;
        repeat (10) tick();
        chk("both_single_cnt", event_cnt, 3);

        // Ack stuck high: timeout after 1024 cycles, then holdoff, sticky flag.
        chk("pre_timeout", timeout, 0);
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        pulse_len(n);
        chk("to_pulse_len", n, 16);
        n = 0;
        while (!timeout && n < 1100) begin tick(); n++; end
        chk("timeout_latency", n, 1024);
        n = 0;
        while (busy && n < 400) begin tick(); n++; end
        chk("timeout_holdoff", n, 256);
        repeat (5) tick();
        chk("timeout_sticky", timeout, 1);
        chk("timeout_cnt", event_cnt, 4);

        // Asynchronous reset in the middle of the pulse.
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        repeat (5) tick();
        chk("mid_pulse_low", rst_req_n, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_req_n", rst_req_n, 1);
        chk("async_busy", busy, 0);
        chk("async_cause", cause, 0);
        chk("async_timeout", timeout, 0);
        chk("async_cnt", event_cnt, 0);
        repeat (2) tick();
        rst = 1'b0;

        // Vector table on the short-timing instance (ack held high: timeout path).
        s_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_en = vt[i].en;
            s_fault = (vt[i].flen > 0);
            tick();
            if (vt[i].flen == 1) s_fault = 1'b0;
            tick();
            tick();
            s_sw = vt[i].sw;
            tick();
            s_sw = 1'b0;
            s_fault = 1'b0;
            chk($sformatf("vec%0d_busy", i), s_busy, vt[i].exp_busy);
            chk($sformatf("vec%0d_rst_req_n", i), s_rstn, !vt[i].exp_busy);
            chk($sformatf("vec%0d_cause", i), s_cause, vt[i].exp_cause);
            chk($sformatf("vec%0d_cnt", i), s_cnt, vt[i].exp_cnt);
            n = 0;
            while (s_busy && n < 100) begin tick(); n++; end
            chk($sformatf("vec%0d_idle", i), s_busy, 0);
            s_en = 1'b1;
            repeat (6) tick();
        end

        // Randomized stimulus against the reference model.
        tick();
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0;
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            s_sw = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) s_fault = ~s_fault;
            if ($urandom_range(0, 5) == 0) s_ack = ~s_ack;
            s_en = ($urandom_range(0, 7) != 0);
            m_step(s_en, s_sw, s_fault, s_ack);
            @(negedge clk);
            dv = {s_rstn, s_busy, s_cause, s_timeout, s_cnt};
            chk("random_outputs", int'(dv), m_outs());
        end

        // 300 requests saturate the 8-bit counter.
        s_rst = 1'b1;
        s_sw = 1'b0; s_fault = 1'b0; s_ack = 1'b1; s_en = 1'b1;
        @(negedge clk);
        s_rst = 1'b0;
        m_reset();
        for (int c = 0; c < 7250; c++) begin
            s_sw = ((c % 24) == 0) && (c < 7200);
            m_step(s_en, s_sw, s_fault, s_ack);
            @(negedge clk);
            dv = {s_rstn, s_busy, s_cause, s_timeout, s_cnt};
            chk("sat_outputs", int'(dv), m_outs());
        end
        s_sw = 1'b0;
        chk("sat_event_cnt", s_cnt, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
